// File: rtl/ov7670_pkg.sv
// ov7670_pkg -- shared constants and types for the OV7670 pixel capture block.
//   H_RES_DEF / V_RES_DEF : default QVGA geometry
//   FRAME_PIXELS          : pixels in one default frame
//   ADDR_W                : frame-buffer word address width
//   cap_state_t           : capture FSM state encoding
package ov7670_pkg;

  localparam int unsigned H_RES_DEF    = 320;
  localparam int unsigned V_RES_DEF    = 240;
  localparam int unsigned FRAME_PIXELS = H_RES_DEF * V_RES_DEF;
  localparam int unsigned ADDR_W       = 17;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    CAPTURE    = 2'd2
  } cap_state_t;

endpackage

// File: rtl/ov7670_in_sync.sv
// ov7670_in_sync -- brings the camera interface into the clk domain.
// Each camera signal passes through a 2-flop synchronizer; pclk, href and
// vsync have a third flop holding the previous synced value for edge detect.
//   clk, reset         : system clock, async active-high reset
//   ov_pclk/href/vsync : raw camera strobes
//   ov_data[7:0]       : raw camera byte bus
//   pclk_rise          : synced pclk went 0->1 this cycle
//   href_fall          : synced href went 1->0 this cycle
//   vsync_rise/fall    : synced vsync edges
//   href_s, data_s     : synchronized href and data, aligned with pclk_rise
module ov7670_in_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic       ov_pclk,
  input  logic       ov_href,
  input  logic       ov_vsync,
  input  logic [7:0] ov_data,
  output logic       pclk_rise,
  output logic       href_fall,
  output logic       vsync_rise,
  output logic       vsync_fall,
  output logic       href_s,
  output logic [7:0] data_s
);

  // bit 0: first sync stage, bit 1: synced value, bit 2: previous synced value
  logic [2:0] pclk_q;
  logic [2:0] href_q;
  logic [2:0] vsync_q;
  logic [7:0] data_q1;
  logic [7:0] data_q2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pclk_q  <= '0;
      href_q  <= '0;
      vsync_q <= '0;
      data_q1 <= '0;
      data_q2 <= '0;
    end else begin
      pclk_q  <= {pclk_q[1:0], ov_pclk};
      href_q  <= {href_q[1:0], ov_href};
      vsync_q <= {vsync_q[1:0], ov_vsync};
      data_q1 <= ov_data;
      data_q2 <= data_q1;
    end
  end

  assign pclk_rise  = pclk_q[1] & ~pclk_q[2];
  assign href_fall  = ~href_q[1] & href_q[2];
  assign vsync_rise = vsync_q[1] & ~vsync_q[2];
  assign vsync_fall = ~vsync_q[1] & vsync_q[2];
  assign href_s     = href_q[1];
  assign data_s     = data_q2;

endmodule

// File: rtl/ov7670_pixel_capture.sv
// ov7670_pixel_capture -- captures RGB565 frames from an OV7670 camera and
// emits one frame-buffer write per pixel.
//   clk, reset  : 100 MHz system clock, async active-high reset
//   en          : capture enable (high once camera is configured)
//   ov_pclk, ov_href, ov_vsync, ov_data[7:0] : raw camera interface
//   wr_en       : one-cycle frame-buffer write strobe
//   wr_addr     : word address y*H_RES+x
//   wr_data     : RGB565 pixel {first byte, second byte}
//   frame_done  : one-cycle pulse at end of each captured frame
//   frame_err   : pixel count mismatch for the last frame, held until next frame_done
module ov7670_pixel_capture
  import ov7670_pkg::*;
#(
  parameter int unsigned H_RES = H_RES_DEF,
  parameter int unsigned V_RES = V_RES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              ov_pclk,
  input  logic              ov_href,
  input  logic              ov_vsync,
  input  logic [7:0]        ov_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              frame_done,
  output logic              frame_err
);

  localparam logic [ADDR_W-1:0] PIX_TOTAL = ADDR_W'(H_RES * V_RES);

  logic       pclk_rise;
  logic       href_fall;
  logic       vsync_rise;
  logic       vsync_fall;
  logic       href_s;
  logic [7:0] data_s;

  ov7670_in_sync u_in_sync (
    .clk        (clk),
    .reset      (reset),
    .ov_pclk    (ov_pclk),
    .ov_href    (ov_href),
    .ov_vsync   (ov_vsync),
    .ov_data    (ov_data),
    .pclk_rise  (pclk_rise),
    .href_fall  (href_fall),
    .vsync_rise (vsync_rise),
    .vsync_fall (vsync_fall),
    .href_s     (href_s),
    .data_s     (data_s)
  );

  cap_state_t        state;
  cap_state_t        state_nxt;
  logic              start_frame;
  logic              end_frame;
  logic              clr_phase;
  logic              byte_strobe;
  logic              phase;
  logic              overrun;
  logic [7:0]        hi_byte;
  logic [ADDR_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Only a vsync falling edge starts a frame, so entering WAIT_FRAME with
  // vsync already low waits for a complete high-then-low cycle.
  // vsync_rise is checked before the pixel path so it wins a same-cycle pclk edge.
  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    clr_phase   = 1'b0;
    byte_strobe = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:       state_nxt = WAIT_FRAME;
        WAIT_FRAME: begin
          if (vsync_fall) begin
            state_nxt   = CAPTURE;
            start_frame = 1'b1;
          end
        end
        CAPTURE: begin
          if (vsync_rise) begin
            state_nxt = WAIT_FRAME;
            end_frame = 1'b1;
          end else if (href_fall) begin
            clr_phase = 1'b1;
          end else if (pclk_rise && href_s) begin
            byte_strobe = 1'b1;
          end
        end
        default:    state_nxt = IDLE;
      endcase
    end
  end

  // overrun remembers pixels dropped after saturation, since count alone
  // cannot tell an exact frame from an oversized one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      phase      <= 1'b0;
      overrun    <= 1'b0;
      hi_byte    <= '0;
      count      <= '0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      if (start_frame) begin
        count   <= '0;
        phase   <= 1'b0;
        wr_addr <= '0;
        overrun <= 1'b0;
      end else if (end_frame) begin
        frame_done <= 1'b1;
        frame_err  <= (count != PIX_TOTAL) | overrun;
      end else if (clr_phase) begin
        phase <= 1'b0;
      end else if (byte_strobe) begin
        phase <= ~phase;
        if (!phase) begin
          hi_byte <= data_s;
        end else if (count == PIX_TOTAL) begin
          overrun <= 1'b1;
        end else begin
          wr_en   <= 1'b1;
          wr_data <= {hi_byte, data_s};
          wr_addr <= count;
          count   <= count + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// tb_ov7670_pixel_capture -- directed self-checking bench for ov7670_pixel_capture.
// Uses a reduced 8x4 frame so full-frame scenarios stay short; camera pclk is clk/4.
module tb_ov7670_pixel_capture;

  localparam int unsigned HR = 8;
  localparam int unsigned VR = 4;
  localparam int unsigned FP = HR * VR;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        ov_pclk;
  logic        ov_href;
  logic        ov_vsync;
  logic [7:0]  ov_data;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [15:0] wr_data;
  logic        frame_done;
  logic        frame_err;

  ov7670_pixel_capture #(.H_RES(HR), .V_RES(VR)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .ov_pclk    (ov_pclk),
    .ov_href    (ov_href),
    .ov_vsync   (ov_vsync),
    .ov_data    (ov_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // write log and frame_done observations, sampled on the falling edge
  logic [16:0] log_addr[$];
  logic [15:0] log_data[$];
  int          log_cyc[$];
  int          rise_q[$];
  int          done_cnt = 0;
  logic        last_err = 1'b0;

  always @(negedge clk) begin
    if (wr_en) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
      log_cyc.push_back(cyc);
    end
    if (frame_done) begin
      done_cnt <= done_cnt + 1;
      last_err <= frame_err;
    end
  end

  int pix;
  int drop_at = -1;
  int up_at   = -1;
  int rst_at  = -1;
  int lb;
  int d0;
  int rq0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // entered and left on a falling clk edge
  task automatic send_byte(input logic [7:0] b);
    ov_pclk = 1'b0;
    ov_data = b;
    repeat (2) @(negedge clk);
    ov_pclk = 1'b1;
    rise_q.push_back(cyc);
    repeat (2) @(negedge clk);
  endtask

  task automatic line_end;
    ov_pclk = 1'b0;
    ov_href = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_begin;
    ov_vsync = 1'b0;
    pix = 0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_end;
    ov_vsync = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic reset_hit;
    @(posedge clk);
    #2;
    check("t6_pre_wr_en", 64'(wr_en), 64'd1);
    check("t6_pre_addr", 64'(wr_addr), 64'(rst_at - 1));
    check("t6_pre_err", 64'(frame_err), 64'd1);
    reset = 1'b1;
    #1;
    check("t6_async_ctl", 64'({wr_en, frame_done, frame_err}), 64'd0);
    check("t6_async_addr", 64'(wr_addr), 64'd0);
    check("t6_async_data", 64'(wr_data), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pixel_line(input int npix, input logic [15:0] base);
    logic [15:0] v;
    ov_href = 1'b1;
    for (int x = 0; x < npix; x++) begin
      if (pix == drop_at) begin
        repeat (4) @(negedge clk);
        en = 1'b0;
      end
      if (pix == up_at) en = 1'b1;
      if (pix == rst_at) reset_hit();
      v = base + 16'(pix);
      send_byte(v[15:8]);
      send_byte(v[7:0]);
      pix++;
    end
    line_end();
  endtask

  task automatic pixel_frame(input int nlines, input logic [15:0] base);
    frame_begin();
    for (int l = 0; l < nlines; l++) pixel_line(HR, base);
    frame_end();
  endtask

  initial begin
    reset    = 1'b1;
    en       = 1'b0;
    ov_pclk  = 1'b0;
    ov_href  = 1'b0;
    ov_vsync = 1'b1;
    ov_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_ctl", 64'({wr_en, frame_done, frame_err}), 64'd0);
    check("reset_addr", 64'(wr_addr), 64'd0);
    check("reset_data", 64'(wr_data), 64'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    en = 1'b1;
    repeat (4) @(negedge clk);

    // full frame, pixel n = n
    lb = log_addr.size();
    d0 = done_cnt;
    pixel_frame(VR, 16'h0000);
    check("t1_writes", 64'(log_addr.size() - lb), 64'(FP));
    for (int i = 0; i < int'(FP); i++)
      check("t1_pixel", 64'({log_addr[lb+i], log_data[lb+i]}), 64'({17'(i), 16'(i)}));
    check("t1_done", 64'(done_cnt - d0), 64'd1);
    check("t1_err", 64'(last_err), 64'd0);

    // single line of two known pixels plus write latency
    check("t2_err_held", 64'(frame_err), 64'd0);
    lb = log_addr.size();
    d0 = done_cnt;
    frame_begin();
    rq0 = rise_q.size();
    ov_href = 1'b1;
    send_byte(8'hF8);
    send_byte(8'h1F);
    send_byte(8'h07);
    send_byte(8'hE0);
    line_end();
    frame_end();
    check("t2_writes", 64'(log_addr.size() - lb), 64'd2);
    check("t2_px0", 64'({log_addr[lb], log_data[lb]}), 64'({17'd0, 16'hF81F}));
    check("t2_px1", 64'({log_addr[lb+1], log_data[lb+1]}), 64'({17'd1, 16'h07E0}));
    check("t2_lat0", 64'(log_cyc[lb] - rise_q[rq0+1]), 64'd3);
    check("t2_lat1", 64'(log_cyc[lb+1] - rise_q[rq0+3]), 64'd3);
    check("t2_done", 64'(done_cnt - d0), 64'd1);
    check("t2_err", 64'(last_err), 64'd1);
    check("t2_err_out", 64'(frame_err), 64'd1);

    // odd trailing byte discarded, next line starts on a high byte
    lb = log_addr.size();
    d0 = done_cnt;
    frame_begin();
    ov_href = 1'b1;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    line_end();
    ov_href = 1'b1;
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    line_end();
    frame_end();
    check("t3_writes", 64'(log_addr.size() - lb), 64'd4);
    check("t3_px0", 64'({log_addr[lb], log_data[lb]}), 64'({17'd0, 16'h1122}));
    check("t3_px1", 64'({log_addr[lb+1], log_data[lb+1]}), 64'({17'd1, 16'h3344}));
    check("t3_px2", 64'({log_addr[lb+2], log_data[lb+2]}), 64'({17'd2, 16'hAABB}));
    check("t3_px3", 64'({log_addr[lb+3], log_data[lb+3]}), 64'({17'd3, 16'hCCDD}));
    check("t3_done", 64'(done_cnt - d0), 64'd1);

    // one line too many: saturate and flag
    lb = log_addr.size();
    d0 = done_cnt;
    pixel_frame(VR + 1, 16'h2000);
    check("t4_long_writes", 64'(log_addr.size() - lb), 64'(FP));
    check("t4_long_last", 64'({log_addr[log_addr.size()-1], log_data[log_data.size()-1]}),
          64'({17'd31, 16'h201F}));
    check("t4_long_done", 64'(done_cnt - d0), 64'd1);
    check("t4_long_err", 64'(last_err), 64'd1);

    // one line short
    lb = log_addr.size();
    d0 = done_cnt;
    pixel_frame(VR - 1, 16'h3000);
    check("t4_short_writes", 64'(log_addr.size() - lb), 64'd24);
    check("t4_short_done", 64'(done_cnt - d0), 64'd1);
    check("t4_short_err", 64'(last_err), 64'd1);

    // asynchronous reset in the middle of a frame
    lb = log_addr.size();
    d0 = done_cnt;
    rst_at = 12;
    pixel_frame(VR, 16'h4000);
    rst_at = -1;
    check("t6_writes", 64'(log_addr.size() - lb), 64'd11);
    check("t6_no_done", 64'(done_cnt - d0), 64'd0);
    lb = log_addr.size();
    d0 = done_cnt;
    pixel_frame(VR, 16'h5000);
    check("t6_next_writes", 64'(log_addr.size() - lb), 64'(FP));
    check("t6_next_first", 64'({log_addr[lb], log_data[lb]}), 64'({17'd0, 16'h5000}));
    check("t6_next_last", 64'({log_addr[lb+31], log_data[lb+31]}), 64'({17'd31, 16'h501F}));
    check("t6_next_done", 64'(done_cnt - d0), 64'd1);
    check("t6_next_err", 64'(last_err), 64'd0);

    // en dropped after pixel 10, re-raised mid-frame
    lb = log_addr.size();
    d0 = done_cnt;
    drop_at = 10;
    up_at   = 20;
    pixel_frame(VR, 16'h6000);
    drop_at = -1;
    up_at   = -1;
    check("t5_writes", 64'(log_addr.size() - lb), 64'd10);
    check("t5_last", 64'({log_addr[log_addr.size()-1], log_data[log_data.size()-1]}),
          64'({17'd9, 16'h6009}));
    check("t5_no_done", 64'(done_cnt - d0), 64'd0);
    lb = log_addr.size();
    d0 = done_cnt;
    pixel_frame(VR, 16'h7000);
    check("t5_next_writes", 64'(log_addr.size() - lb), 64'(FP));
    check("t5_next_first", 64'({log_addr[lb], log_data[lb]}), 64'({17'd0, 16'h7000}));
    check("t5_next_done", 64'(done_cnt - d0), 64'd1);
    check("t5_next_err", 64'(last_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ov7670_pixel_capture.md
OV7670_PIXEL_CAPTURE -- requirements
Module: ov7670_pixel_capture

Interface
REQ-001 Parameter H_RES, default 320, pixels per line (QVGA).
REQ-002 Parameter V_RES, default 240, lines per frame.
REQ-003 clk  input  1  system clock, 100 MHz; the block uses one clock only.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  capture enable, driven high once camera register configuration has completed.
REQ-006 ov_pclk  input  1  camera pixel clock, sampled as data; frequency at most clk/4.
REQ-007 ov_href  input  1  camera line-valid.
REQ-008 ov_vsync  input  1  camera frame sync; high during vertical blanking.
REQ-009 ov_data  input  8  camera byte bus; RGB565, high byte first.
REQ-010 wr_en  output  1  one-cycle frame-buffer write strobe.
REQ-011 wr_addr  output  17  frame-buffer word address, row-major, y*H_RES+x.
REQ-012 wr_data  output  16  RGB565 pixel, {first byte, second byte}.
REQ-013 frame_done  output  1  one-cycle pulse at end of each captured frame.
REQ-014 frame_err  output  1  valid with frame_done; 1 = pixel count differed from H_RES*V_RES.

Function
REQ-015 ov_pclk, ov_href, ov_vsync and ov_data shall each pass through a 2-flop synchronizer; a third flop provides edge detection.
REQ-016 Pclk rising edge = synced 1 and previous 0; ov_data and ov_href shall be sampled from the synchronized stage in that same cycle.
REQ-017 FSM states: IDLE, WAIT_FRAME, CAPTURE.
REQ-018 IDLE -> WAIT_FRAME when en=1.
REQ-019 WAIT_FRAME -> CAPTURE on synced vsync falling edge; the pixel counter, byte phase and address clear on this transition.
REQ-020 In CAPTURE, each pclk edge with href=1 shall toggle the byte phase: phase 0 latches the high byte; phase 1 forms the pixel.
REQ-021 On phase 1, wr_en shall pulse for one cycle and wr_data={hi,lo}; wr_addr shall equal the pixel count; the count then increments.
REQ-022 Latency: wr_en shall assert exactly 3 clk cycles after the raw ov_pclk rising edge carrying the low byte.
REQ-023 Href falling edge shall reset the byte phase to 0, so an odd trailing byte is discarded without a write.
REQ-024 Once the count reaches H_RES*V_RES, further pixels in the frame shall be dropped with no wr_en, and the address shall saturate at H_RES*V_RES-1.
REQ-025 CAPTURE -> WAIT_FRAME on synced vsync rising edge: frame_done shall pulse for 1 cycle, and frame_err=1 iff count != H_RES*V_RES (short or overrun).
REQ-026 frame_err shall hold its value until the next frame_done.
REQ-027 en=0 in any state shall force IDLE on the next cycle with no frame_done, abandoning a partial frame.
REQ-028 If entry to WAIT_FRAME occurs while vsync is already low mid-frame, the block shall wait for the next full vsync high-then-low cycle.
REQ-029 If vsync rises and a pclk edge occur in the same cycle, the vsync edge shall win and that pixel shall not be written.

Reset
REQ-030 On reset: state IDLE; wr_en, wr_data, wr_addr, frame_done and frame_err = 0; synchronizers, counters and byte phase = 0.
REQ-031 Reset release mid-frame shall behave as REQ-028.

Structure
REQ-032 Package ov7670_pkg shall hold H_RES_DEF, V_RES_DEF, FRAME_PIXELS, ADDR_W=17 and the capture-state enum typedef.
REQ-033 Sub-module ov7670_in_sync shall contain the synchronizers and the edge detectors, and shall output pclk_rise, href_fall, vsync_rise, vsync_fall, href_s and data_s.

Verification
REQ-034 Test 1: en=1, full 320x240 frame, pclk=clk/4, pixel(n)=n[15:0] -> 76800 wr_en pulses, addr 0..76799, data matching; frame_done=1 and frame_err=0.
REQ-035 Test 2: one line of 0xF8,0x1F,0x07,0xE0 -> writes 0xF81F at addr 0 and 0x07E0 at addr 1, each 3 clk after its second raw pclk edge.
REQ-036 Test 3: 5-byte href pulse -> exactly 2 writes; the next line starts at byte phase 0.
REQ-037 Test 4: frame of 241 lines -> 76800 writes, last addr 76799, and frame_err=1 at frame_done; 239-line frame -> frame_err=1.
REQ-038 Test 5: en dropped at pixel 1000 -> no further wr_en and no frame_done; en re-raised mid-frame -> capture starts only after the next vsync falling edge.
REQ-039 Test 6: reset asserted mid-CAPTURE -> all outputs 0 within the same cycle (asynchronous); after release, no write until a full vsync cycle.
